// File: rtl/spi_pixel_rx_pkg.sv
// Shared types and constants for the SPI pixel receiver.
package spi_pixel_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_DRAIN = 2'd2,
    RX_DONE  = 2'd3
  } rx_state_t;

  // SCLK may run at most at clk/SCLK_MIN_DIV so the synchronizers see every edge.
  localparam int SCLK_MIN_DIV = 8;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_pixel_rx_byte_fifo.sv
// Small power-of-two byte FIFO with extra-MSB pointers; push and pop may
// coincide at any occupancy, including full.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/spi_pixel_rx.sv
// SPI mode-0 slave receiving MSB-first grayscale pixels, buffering them in a
// byte FIFO and handing them downstream with a valid/ready pair.
module spi_pixel_rx
  import spi_pixel_rx_pkg::*;
#(
  parameter int CLOCK_SPEED      = 50000000,
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        spi_sclk,
  input  logic                        spi_mosi,
  input  logic                        spi_cs_n,
  output logic                        spi_miso,
  input  logic                        MCU_RX_RDY,
  output logic                        MCU_TX_RDY,
  output logic [RGB_SIZE-1:0]         external_SPI_data,
  output logic [IMAGE_ADDR_WIDTH:0]   pixel_count,
  output logic                        frame_done,
  output logic                        overflow,
  output rx_state_t                   dbg_state
);

  localparam int BIT_W = $clog2(RGB_SIZE);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BIT_W-1:0]          LAST_BIT     = BIT_W'(RGB_SIZE - 1);
  localparam logic [IMAGE_ADDR_WIDTH:0] FRAME_PIXELS = (IMAGE_ADDR_WIDTH + 1)'(IMAGE_SIZE);
  localparam logic [CNT_W-1:0]          MISO_LIMIT   = CNT_W'(FIFO_DEPTH - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      CLOCK_SPEED < SCLK_MIN_DIV || RGB_SIZE < 3) begin : g_param_check
    $error("spi_pixel_rx: unsupported parameter set");
  end

  // Handshake: a pixel moves downstream on every clk edge where MCU_TX_RDY
  // and MCU_RX_RDY are both 1; external_SPI_data holds while MCU_TX_RDY=1
  // and MCU_RX_RDY=0, and MCU_TX_RDY never drops without a transfer.

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  rx_state_t state_q, state_d;

  logic [BIT_W-1:0]          bit_cnt_q;
  logic [RGB_SIZE-2:0]       shift_q;
  logic [RGB_SIZE-1:0]       byte_q;
  logic                      byte_valid_q;
  logic [IMAGE_ADDR_WIDTH:0] pixel_count_q;
  logic                      frame_done_q;
  logic                      overflow_q;
  logic                      miso_q;

  logic                      frame_start;
  logic                      accept_byte;
  logic                      shift_en;
  logic                      pix_at_max;
  logic                      pop;
  logic                      drop;
  logic                      fifo_full, fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [RGB_SIZE-1:0]       fifo_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  assign pix_at_max = (pixel_count_q == FRAME_PIXELS);
  assign pop        = MCU_TX_RDY & MCU_RX_RDY;
  // Bytes still shift in RX_DONE so that surplus bytes can be flagged.
  assign shift_en   = (state_q == RX_SHIFT) || (state_q == RX_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RX_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    accept_byte = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (cs_fall) begin
          frame_start = 1'b1;
          state_d     = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        accept_byte = byte_valid_q;
        if (pix_at_max)   state_d = RX_DONE;
        else if (cs_rise) state_d = RX_DRAIN;
      end
      RX_DRAIN: begin
        // A byte completed right as cs_n rose still belongs to this frame.
        accept_byte = byte_valid_q;
        if (pix_at_max)                       state_d = RX_DONE;
        else if (fifo_empty && !byte_valid_q) state_d = RX_IDLE;
      end
      RX_DONE: begin
        if (cs_fall) begin
          frame_start = 1'b1;
          state_d     = RX_SHIFT;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign drop = (accept_byte & fifo_full & ~pop) |
                (byte_valid_q & (state_q == RX_DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (frame_start || cs_rise) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else if (sclk_rise && !cs_s && shift_en) begin
        shift_q   <= {shift_q[RGB_SIZE-3:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          byte_q       <= {shift_q, mosi_s};
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_count_q <= '0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      miso_q        <= 1'b1;
    end else begin
      if (frame_start) begin
        pixel_count_q <= '0;
        overflow_q    <= 1'b0;
      end else begin
        if (pop && !pix_at_max) pixel_count_q <= pixel_count_q + 1'b1;
        if (drop)               overflow_q    <= 1'b1;
      end
      frame_done_q <= (state_d == RX_DONE);
      miso_q       <= (fifo_count < MISO_LIMIT);
    end
  end

  byte_fifo #(
    .WIDTH (RGB_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (accept_byte),
    .data_i  (byte_q),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign MCU_TX_RDY        = ~fifo_empty;
  assign external_SPI_data = fifo_head;
  assign pixel_count       = pixel_count_q;
  assign frame_done        = frame_done_q;
  assign overflow          = overflow_q;
  assign spi_miso          = miso_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Directed bench for spi_pixel_rx: table-driven pixel vectors plus hand
// sequences for backpressure, partial bytes, frame end and async reset.
module tb_spi_pixel_rx;
  import spi_pixel_rx_pkg::*;

  localparam int IMAGEX     = 8;
  localparam int IMAGEY     = 4;
  localparam int IMAGE_SIZE = IMAGEX * IMAGEY;
  localparam int AW         = $clog2(IMAGE_SIZE);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          spi_sclk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_miso;
  logic          MCU_RX_RDY = 1'b0;
  logic          MCU_TX_RDY;
  logic [7:0]    external_SPI_data;
  logic [AW:0]   pixel_count;
  logic          frame_done;
  logic          overflow;
  rx_state_t     dbg_state;

  spi_pixel_rx #(
    .IMAGEX (IMAGEX),
    .IMAGEY (IMAGEY)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .spi_sclk          (spi_sclk),
    .spi_mosi          (spi_mosi),
    .spi_cs_n          (spi_cs_n),
    .spi_miso          (spi_miso),
    .MCU_RX_RDY        (MCU_RX_RDY),
    .MCU_TX_RDY        (MCU_TX_RDY),
    .external_SPI_data (external_SPI_data),
    .pixel_count       (pixel_count),
    .frame_done        (frame_done),
    .overflow          (overflow),
    .dbg_state         (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int tx_high_cnt   = 0;
  int tx_rise_cyc   = -1;
  int last_rise_cyc = 0;
  logic tx_prev = 1'b0;

  // monitor: a transfer happens at the posedge following this negedge
  always @(negedge clk) begin
    if (MCU_TX_RDY) tx_high_cnt++;
    if (MCU_TX_RDY && !tx_prev) tx_rise_cyc = cyc;
    tx_prev = MCU_TX_RDY;
    if (MCU_TX_RDY && MCU_RX_RDY) got_q.push_back(external_SPI_data);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // SCLK = clk/8, mode 0, MSB first
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      tick(4);
      spi_sclk = 1'b1;
      last_rise_cyc = cyc;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    tick(10);
  endtask

  task automatic check_pops(input string name);
    logic [7:0] e;
    int t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = 0;
      while (got_q.size() == 0 && t < 400) begin
        tick(1);
        t++;
      end
      if (got_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s: no pixel within 400 clk, expected %02h", name, e);
      end else begin
        check(name, got_q.pop_front(), e);
      end
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_data;
    int         exp_count;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1};
    vecs[1] = '{8'hFF, 8'hFF, 2};
    vecs[2] = '{8'h5A, 8'h5A, 3};
    vecs[3] = '{8'h81, 8'h81, 4};
    vecs[4] = '{8'h7E, 8'h7E, 5};

    // reset
    tick(3);
    check("rst_tx_rdy", MCU_TX_RDY, 0);
    check("rst_data", external_SPI_data, 0);
    check("rst_count", pixel_count, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_miso", spi_miso, 1);
    check("rst_state", dbg_state, RX_IDLE);
    rst = 1'b1;
    tick(3);

    // single byte with latency and pulse width
    MCU_RX_RDY = 1'b1;
    cs_low();
    check("frame_state", dbg_state, RX_SHIFT);
    tx_high_cnt = 0;
    tx_rise_cyc = -1;
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    check_pops("single_data");
    tick(3);
    check("single_count", pixel_count, 1);
    check("single_pulse", tx_high_cnt, 1);
    check("single_latency_le4", (tx_rise_cyc - last_rise_cyc >= 1) && (tx_rise_cyc - last_rise_cyc <= 4), 1);
    cs_high();
    check("single_idle", dbg_state, RX_IDLE);

    // table-driven vectors
    cs_low();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp_data);
      send_bits(vecs[i].tx, 8);
      check_pops("vec_data");
      check("vec_count", pixel_count, vecs[i].exp_count);
    end
    cs_high();

    // backpressure and overflow
    MCU_RX_RDY = 1'b0;
    cs_low();
    check("bp_ovf_cleared", overflow, 0);
    check("bp_count_cleared", pixel_count, 0);
    send_bits(8'h11, 8); tick(2);
    check("bp_miso_1", spi_miso, 1);
    send_bits(8'h12, 8); tick(2);
    check("bp_miso_2", spi_miso, 1);
    send_bits(8'h13, 8); tick(2);
    check("bp_miso_3", spi_miso, 0);
    send_bits(8'h14, 8); tick(2);
    check("bp_hold_valid", MCU_TX_RDY, 1);
    check("bp_hold_data", external_SPI_data, 8'h11);
    check("bp_no_ovf_yet", overflow, 0);
    send_bits(8'h15, 8); tick(2);
    check("bp_ovf", overflow, 1);
    check("bp_hold_data2", external_SPI_data, 8'h11);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h14);
    MCU_RX_RDY = 1'b1;
    check_pops("bp_order");
    tick(3);
    check("bp_count", pixel_count, 4);
    check("bp_empty", MCU_TX_RDY, 0);
    check("bp_miso_back", spi_miso, 1);
    cs_high();

    // partial byte then a clean frame
    cs_low();
    send_bits(8'hE8, 5);
    cs_high();
    check("partial_no_push", MCU_TX_RDY, 0);
    check("partial_idle", dbg_state, RX_IDLE);
    check("partial_nothing_out", got_q.size(), 0);
    cs_low();
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    check_pops("partial_next");
    check("partial_next_count", pixel_count, 1);
    cs_high();

    // full frame
    cs_low();
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      exp_q.push_back(8'((i * 37 + 5) & 8'hFF));
      send_bits(8'((i * 37 + 5) & 8'hFF), 8);
    end
    check_pops("frame_data");
    tick(3);
    check("frame_count", pixel_count, IMAGE_SIZE);
    check("frame_done", frame_done, 1);
    check("frame_state", dbg_state, RX_DONE);
    check("frame_no_ovf", overflow, 0);
    tx_high_cnt = 0;
    send_bits(8'h99, 8);
    tick(4);
    check("extra_ovf", overflow, 1);
    check("extra_no_valid", tx_high_cnt, 0);
    check("extra_count_sat", pixel_count, IMAGE_SIZE);
    check("extra_done_held", frame_done, 1);
    spi_cs_n = 1'b1;
    tick(6);
    cs_low();
    tick(2);
    check("restart_state", dbg_state, RX_SHIFT);
    check("restart_done", frame_done, 0);
    check("restart_ovf", overflow, 0);
    check("restart_count", pixel_count, 0);

    // async reset mid-byte
    exp_q.push_back(8'h41);
    send_bits(8'h41, 8);
    check_pops("ar_first");
    MCU_RX_RDY = 1'b0;
    send_bits(8'h42, 8);
    tick(2);
    check("ar_held", MCU_TX_RDY, 1);
    send_bits(8'hC3, 4);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("ar_tx_rdy", MCU_TX_RDY, 0);
    check("ar_data", external_SPI_data, 0);
    check("ar_count", pixel_count, 0);
    check("ar_state", dbg_state, RX_IDLE);
    check("ar_miso", spi_miso, 1);
    tick(2);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tick(2);
    rst = 1'b1;
    got_q.delete();
    exp_q.delete();
    tick(4);
    MCU_RX_RDY = 1'b1;
    cs_low();
    exp_q.push_back(8'hFF);
    send_bits(8'hFF, 8);
    check_pops("ar_after");
    check("ar_after_count", pixel_count, 1);
    check("ar_after_ovf", overflow, 0);
    cs_high();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
